time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/time_set_ctrl.sv | 179 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-set controller: state encoding,
// time field widths and field wrap limits.
package time_set_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [HOUR_W-1:0] HOUR_MAX   = 5'd23;
    localparam logic [MIN_W-1:0]  MINSEC_MAX = 6'd59;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    // Values at or above the limit (e.g. an out-of-range capture) also wrap to 0.
    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] vmax);
        return (v >= vmax) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low pushbutton -> 2-flop synchronizer -> debouncer -> one-cycle
// press pulse on the debounced 1->0 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_arm_cnt;
    logic             r_armed;
    logic             r_press;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync0   <= 1'b1;
            r_sync1   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync0   <= i_btn_n;
            r_sync1   <= r_sync0;
            r_level_d <= r_level;
            r_press   <= r_armed & r_level_d & ~r_level;

            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A button held through reset stays unarmed until seen stably released.
            if (!r_armed) begin
                if (!r_sync1) begin
                    r_arm_cnt <= '0;
                end else if (r_arm_cnt == CNT_LAST) begin
                    r_armed   <= 1'b1;
                    r_arm_cnt <= '0;
                end else begin
                    r_arm_cnt <= r_arm_cnt + 1'b1;
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Two-button time-set controller: captures the live time, lets the user edit
// hour/min/sec with a blinking field, then loads it back into the clock core.
//
// state       | meaning
// ST_RUN      | clock runs, mode press captures cur_* and starts an edit
// ST_SET_HOUR | editing hours, hour digits blink
// ST_SET_MIN  | editing minutes, minute digits blink
// ST_SET_SEC  | editing seconds, second digits blink
// ST_COMMIT   | single cycle with load=1, then back to ST_RUN
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [HOUR_W-1:0] cur_hour,
    output logic              run,
    output logic              load,
    output logic [SEC_W-1:0]  load_sec,
    output logic [MIN_W-1:0]  load_min,
    output logic [HOUR_W-1:0] load_hour,
    output logic [2:0]        blank
);

    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic w_mode_press;
    logic w_inc_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (btn_mode),
        .o_press (w_mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (btn_inc),
        .o_press (w_inc_press)
    );

    state_t            r_state;
    logic              r_run;
    logic              r_load;
    logic [2:0]        r_blank;
    logic [SEC_W-1:0]  r_sh_sec;
    logic [MIN_W-1:0]  r_sh_min;
    logic [HOUR_W-1:0] r_sh_hour;
    logic [BL_W-1:0]   r_blink_cnt;
    logic              r_phase;
    logic [TO_W-1:0]   r_to_cnt;

    state_t            w_state_nxt;
    logic              w_in_set;
    logic              w_set_nxt;
    logic              w_entry;
    logic              w_inc_ok;
    logic              w_timeout;
    logic [BL_W-1:0]   w_blink_cnt_nxt;
    logic              w_phase_nxt;
    logic [TO_W-1:0]   w_to_cnt_nxt;
    logic [2:0]        w_blank_nxt;
    logic [HOUR_W-1:0] w_hour_inc;
    logic [MIN_W-1:0]  w_min_inc;
    logic [SEC_W-1:0]  w_sec_inc;

    assign w_hour_inc = HOUR_W'(inc_wrap({1'b0, r_sh_hour}, {1'b0, HOUR_MAX}));
    assign w_min_inc  = inc_wrap(r_sh_min, MINSEC_MAX);
    assign w_sec_inc  = inc_wrap(r_sh_sec, MINSEC_MAX);

    assign w_in_set  = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) || (r_state == ST_SET_SEC);
    assign w_inc_ok  = w_in_set & w_inc_press & ~w_mode_press;
    assign w_timeout = (r_to_cnt == TO_LAST) & ~w_mode_press & ~w_inc_press;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (w_mode_press) w_state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: if (w_mode_press) w_state_nxt = ST_SET_MIN;
                         else if (w_timeout) w_state_nxt = ST_RUN;
            ST_SET_MIN:  if (w_mode_press) w_state_nxt = ST_SET_SEC;
                         else if (w_timeout) w_state_nxt = ST_RUN;
            ST_SET_SEC:  if (w_mode_press) w_state_nxt = ST_COMMIT;
                         else if (w_timeout) w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    assign w_set_nxt = (w_state_nxt == ST_SET_HOUR) || (w_state_nxt == ST_SET_MIN) ||
                       (w_state_nxt == ST_SET_SEC);
    assign w_entry   = w_set_nxt && (w_state_nxt != r_state);

    // Blink restarts visible on every field entry and every accepted increment.
    always_comb begin
        w_blink_cnt_nxt = '0;
        w_phase_nxt     = 1'b0;
        if (w_set_nxt && !w_entry && !w_inc_ok) begin
            if (r_blink_cnt == BL_LAST) begin
                w_phase_nxt = ~r_phase;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                w_phase_nxt     = r_phase;
            end
        end
    end

    always_comb begin
        w_to_cnt_nxt = '0;
        if (w_set_nxt && !w_entry && !w_mode_press && !w_inc_press) begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_blank_nxt = 3'b000;
        case (w_state_nxt)
            ST_SET_HOUR: w_blank_nxt = {w_phase_nxt, 2'b00};
            ST_SET_MIN:  w_blank_nxt = {1'b0, w_phase_nxt, 1'b0};
            ST_SET_SEC:  w_blank_nxt = {2'b00, w_phase_nxt};
            default:     w_blank_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_run       <= 1'b1;
            r_load      <= 1'b0;
            r_blank     <= 3'b000;
            r_sh_sec    <= '0;
            r_sh_min    <= '0;
            r_sh_hour   <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= (w_state_nxt == ST_RUN);
            r_load      <= (w_state_nxt == ST_COMMIT);
            r_blank     <= w_blank_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_to_cnt    <= w_to_cnt_nxt;

            if ((r_state == ST_RUN) && w_mode_press) begin
                r_sh_sec  <= cur_sec;
                r_sh_min  <= cur_min;
                r_sh_hour <= cur_hour;
            end else if (w_inc_ok) begin
                case (r_state)
                    ST_SET_HOUR: r_sh_hour <= w_hour_inc;
                    ST_SET_MIN:  r_sh_min  <= w_min_inc;
                    ST_SET_SEC:  r_sh_sec  <= w_sec_inc;
                    default:     ;
                endcase
            end
        end
    end

    assign run       = r_run;
    assign load      = r_load;
    assign blank     = r_blank;
    assign load_sec  = r_sh_sec;
    assign load_min  = r_sh_min;
    assign load_hour = r_sh_hour;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/blink/timeout settings.
module tb_time_set_ctrl;
    import time_set_pkg::*;

    localparam int DB = 4;
    localparam int BL = 8;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_inc = 1'b1;
    logic [5:0] cur_sec = '0;
    logic [5:0] cur_min = '0;
    logic [4:0] cur_hour = '0;
    logic       run;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hour;
    logic [2:0] blank;

    int n_checks = 0;
    int n_fail = 0;
    int n_load = 0;
    logic [5:0] ld_s = '0;
    logic [5:0] ld_m = '0;
    logic [4:0] ld_h = '0;
    logic       run_at_load = 1'b1;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .BLINK_CYCLES    (BL),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_sec   (cur_sec),
        .cur_min   (cur_min),
        .cur_hour  (cur_hour),
        .run       (run),
        .load      (load),
        .load_sec  (load_sec),
        .load_min  (load_min),
        .load_hour (load_hour),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            n_load      <= n_load + 1;
            ld_s        <= load_sec;
            ld_m        <= load_min;
            ld_h        <= load_hour;
            run_at_load <= run;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic m, input logic i);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        if (m) btn_mode = 1'b0;
        if (i) btn_inc = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dut.u_db_mode.o_press || dut.u_db_inc.o_press) seen = 1'b1;
        end
        chk("press_seen", 32'(seen), 32'd1);
        @(negedge clk);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic blink_scan(input logic [2:0] mask, input string tag);
        int bad;
        int seen;
        bad = 0;
        seen = 0;
        repeat (24) begin
            @(negedge clk);
            if ((blank & ~mask) != 3'b000) bad++;
            if ((blank & mask) != 3'b000) seen++;
        end
        chk({tag, "_other_bits"}, 32'(bad), 32'd0);
        chk({tag, "_blinks"}, 32'(seen > 0), 32'd1);
    endtask

    task automatic chk_time(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s);
        chk({tag, "_hour"}, 32'(load_hour), 32'(h));
        chk({tag, "_min"},  32'(load_min),  32'(m));
        chk({tag, "_sec"},  32'(load_sec),  32'(s));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dut.r_state), 32'(ST_RUN));
        chk("rst_run", 32'(run), 32'd1);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        chk_time("rst", 5'd0, 6'd0, 6'd0);
        reset = 1'b1;
        repeat (12) @(negedge clk);

        // full edit: 12:34:56 -> 15:35:56
        press(1'b1, 1'b0);
        chk("edit_state_hour", 32'(dut.r_state), 32'(ST_SET_HOUR));
        chk("edit_run", 32'(run), 32'd0);
        chk_time("capture", 5'd12, 6'd34, 6'd56);
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        blink_scan(3'b100, "blink_hour");
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk_time("inc_hour", 5'd15, 6'd34, 6'd56);
        press(1'b1, 1'b0);
        chk("edit_state_min", 32'(dut.r_state), 32'(ST_SET_MIN));
        press(1'b0, 1'b1);
        chk_time("inc_min", 5'd15, 6'd35, 6'd56);
        blink_scan(3'b010, "blink_min");
        press(1'b1, 1'b0);
        chk("edit_state_sec", 32'(dut.r_state), 32'(ST_SET_SEC));
        blink_scan(3'b001, "blink_sec");
        press(1'b1, 1'b0);
        chk("commit_state", 32'(dut.r_state), 32'(ST_RUN));
        chk("commit_loads", 32'(n_load), 32'd1);
        chk("commit_val_h", 32'(ld_h), 32'd15);
        chk("commit_val_m", 32'(ld_m), 32'd35);
        chk("commit_val_s", 32'(ld_s), 32'd56);
        chk("commit_run_at_load", 32'(run_at_load), 32'd0);
        chk("commit_run_after", 32'(run), 32'd1);
        chk("commit_blank", 32'(blank), 32'd0);
        press(1'b0, 1'b1);
        chk("run_inc_ignored_state", 32'(dut.r_state), 32'(ST_RUN));
        chk_time("run_inc_ignored", 5'd15, 6'd35, 6'd56);

        // wrap: 23:59:10
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd10;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk_time("wrap_hour", 5'd0, 6'd59, 6'd10);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk_time("wrap_min", 5'd0, 6'd0, 6'd10);

        // 3-cycle glitch in SET_MIN
        @(negedge clk);
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        btn_inc = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_min", 32'(load_min), 32'd0);
        chk("glitch_state", 32'(dut.r_state), 32'(ST_SET_MIN));

        // clean press latency, then blink restart after the increment
        @(negedge clk);
        btn_inc = 1'b0;
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (dut.u_db_inc.o_press) begin
                lat = k;
                break;
            end
        end
        chk("press_latency", 32'(lat), 32'd6);
        @(negedge clk);
        btn_inc = 1'b1;
        chk("press_width", 32'(dut.u_db_inc.o_press), 32'd0);
        chk("latency_inc_min", 32'(load_min), 32'd1);
        chk("blink_restart", 32'(blank), 32'd0);
        repeat (7) @(negedge clk);
        chk("blink_hold", 32'(blank), 32'd0);
        @(negedge clk);
        chk("blink_toggle", 32'(blank), 32'b010);
        repeat (10) @(negedge clk);

        // timeout in SET_SEC
        press(1'b1, 1'b0);
        chk("to_state_sec", 32'(dut.r_state), 32'(ST_SET_SEC));
        repeat (40) @(negedge clk);
        chk("to_not_yet", 32'(dut.r_state), 32'(ST_SET_SEC));
        repeat (30) @(negedge clk);
        chk("to_state", 32'(dut.r_state), 32'(ST_RUN));
        chk("to_run", 32'(run), 32'd1);
        chk("to_blank", 32'(blank), 32'd0);
        chk("to_no_load", 32'(n_load), 32'd1);
        chk_time("to_kept", 5'd0, 6'd1, 6'd10);

        // simultaneous mode+inc in SET_HOUR
        cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk("simul_state", 32'(dut.r_state), 32'(ST_SET_MIN));
        chk_time("simul", 5'd5, 6'd6, 6'd7);

        // reset mid-edit with mode held through it
        @(negedge clk);
        reset = 1'b0;
        btn_mode = 1'b0;
        @(negedge clk);
        chk("midrst_state", 32'(dut.r_state), 32'(ST_RUN));
        chk("midrst_run", 32'(run), 32'd1);
        chk("midrst_load", 32'(load), 32'd0);
        chk("midrst_blank", 32'(blank), 32'd0);
        chk_time("midrst", 5'd0, 6'd0, 6'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_no_press", 32'(dut.r_state), 32'(ST_RUN));
        btn_mode = 1'b1;
        repeat (15) @(negedge clk);
        press(1'b1, 1'b0);
        chk("repress_state", 32'(dut.r_state), 32'(ST_SET_HOUR));
        chk("repress_capture", 32'(load_hour), 32'd5);
        chk("midrst_no_load", 32'(n_load), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
